// File: rtl/usb_pkg.sv
// Shared USB host definitions: RX packet-type encoding and host FSM states.
package usb_pkg;

  localparam logic [1:0] RX_NONE = 2'b00;
  localparam logic [1:0] RX_ACK  = 2'b01;
  localparam logic [1:0] RX_NAK  = 2'b10;
  localparam logic [1:0] RX_DATA = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_TOKEN_IN  = 4'd1,
    S_WAIT_DATA = 4'd2,
    S_SEND_ACK  = 4'd3,
    S_TOKEN_OUT = 4'd4,
    S_SEND_DATA = 4'd5,
    S_WAIT_HS   = 4'd6,
    S_RETRY     = 4'd7,
    S_DONE      = 4'd8,
    S_ERROR     = 4'd9
  } host_state_t;

endpackage

// File: rtl/bulk_timeout_timer.sv
// Wait-state cycle counter. expired is high on the last allowed cycle,
// i.e. after TIMEOUT_CYC cycles of count_en following a clear.
// Ports: clk, rst (async, active high), clear (synchronous zero),
//        count_en (advance one per cycle), expired (combinational flag).
module bulk_timeout_timer #(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYC);

  logic [TW-1:0] cnt;

  // Counter: clear has priority over counting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (count_en) begin
      cnt <= cnt + TW'(1);
    end
  end

  assign expired = count_en && (cnt == TW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/bulk_host_initiator.sv
// Host-side bulk transaction initiator: issues IN/OUT tokens, moves DATA and
// handshakes through shared TX/RX engines, and retries on NAK/unexpected/timeout.
// Ports: clk, rst (async, active high); requests start_in/start_out/abort;
//        engine status tx_complete, rx_valid, rx_type; engine controls tx_en,
//        send_in_tok, send_out_tok, send_data, send_ack, rx_en; status busy,
//        xfer_done, xfer_err, retry_cnt. All outputs are registered.
module bulk_host_initiator
  import usb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 16,
  parameter int unsigned MAX_RETRY   = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start_in,
  input  logic                           start_out,
  input  logic                           abort,
  input  logic                           tx_complete,
  input  logic                           rx_valid,
  input  logic [1:0]                     rx_type,
  output logic                           tx_en,
  output logic                           send_in_tok,
  output logic                           send_out_tok,
  output logic                           send_data,
  output logic                           send_ack,
  output logic                           rx_en,
  output logic                           busy,
  output logic                           xfer_done,
  output logic                           xfer_err,
  output logic [$clog2(MAX_RETRY+1)-1:0] retry_cnt
);

  localparam int unsigned RW = $clog2(MAX_RETRY + 1);

  host_state_t state;
  host_state_t nxt;
  logic        dir_in;
  logic        in_wait;
  logic        expired;

  assign in_wait = (state == S_WAIT_DATA) || (state == S_WAIT_HS);

  // Timer is held at zero outside the wait states, so it starts from zero on entry.
  bulk_timeout_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    (!in_wait),
    .count_en (in_wait),
    .expired  (expired)
  );

  // Next-state decode; a received packet beats a coinciding timeout, abort beats all.
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE: begin
        if (start_in)       nxt = S_TOKEN_IN;
        else if (start_out) nxt = S_TOKEN_OUT;
      end
      S_TOKEN_IN:  if (tx_complete) nxt = S_WAIT_DATA;
      S_WAIT_DATA: begin
        if (rx_valid)     nxt = (rx_type == RX_DATA) ? S_SEND_ACK : S_RETRY;
        else if (expired) nxt = S_RETRY;
      end
      S_SEND_ACK:  if (tx_complete) nxt = S_DONE;
      S_TOKEN_OUT: if (tx_complete) nxt = S_SEND_DATA;
      S_SEND_DATA: if (tx_complete) nxt = S_WAIT_HS;
      S_WAIT_HS: begin
        if (rx_valid)     nxt = (rx_type == RX_ACK) ? S_DONE : S_RETRY;
        else if (expired) nxt = S_RETRY;
      end
      S_RETRY: begin
        if (retry_cnt == RW'(MAX_RETRY)) nxt = S_ERROR;
        else                             nxt = dir_in ? S_TOKEN_IN : S_TOKEN_OUT;
      end
      S_DONE:  nxt = S_IDLE;
      S_ERROR: nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
    if (abort) nxt = S_IDLE;
  end

  // State, direction, retry counter and outputs; outputs decode the state being entered
  // so they line up with the registered state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      dir_in       <= 1'b0;
      retry_cnt    <= '0;
      tx_en        <= 1'b0;
      send_in_tok  <= 1'b0;
      send_out_tok <= 1'b0;
      send_data    <= 1'b0;
      send_ack     <= 1'b0;
      rx_en        <= 1'b0;
      busy         <= 1'b0;
      xfer_done    <= 1'b0;
      xfer_err     <= 1'b0;
    end else begin
      state <= nxt;
      if (state == S_IDLE && nxt != S_IDLE) dir_in <= start_in;

      if (nxt == S_IDLE)                                      retry_cnt <= '0;
      else if (state == S_RETRY && nxt != S_ERROR)            retry_cnt <= retry_cnt + RW'(1);

      send_in_tok  <= (nxt == S_TOKEN_IN);
      send_out_tok <= (nxt == S_TOKEN_OUT);
      send_data    <= (nxt == S_SEND_DATA);
      send_ack     <= (nxt == S_SEND_ACK);
      tx_en        <= (nxt == S_TOKEN_IN) || (nxt == S_TOKEN_OUT) ||
                      (nxt == S_SEND_DATA) || (nxt == S_SEND_ACK);
      rx_en        <= (nxt == S_WAIT_DATA) || (nxt == S_WAIT_HS);
      busy         <= (nxt != S_IDLE);
      xfer_done    <= (nxt == S_DONE);
      xfer_err     <= (nxt == S_ERROR);
    end
  end

endmodule

// File: tb/tb_bulk_host_initiator.sv
// Directed self-checking bench for bulk_host_initiator (default parameters).
module tb_bulk_host_initiator;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_in = 1'b0;
  logic       start_out = 1'b0;
  logic       abort = 1'b0;
  logic       tx_complete = 1'b0;
  logic       rx_valid = 1'b0;
  logic [1:0] rx_type = 2'b00;
  logic       tx_en, send_in_tok, send_out_tok, send_data, send_ack, rx_en;
  logic       busy, xfer_done, xfer_err;
  logic [1:0] retry_cnt;

  int checks = 0;
  int failures = 0;

  // Event tallies gathered at every clock edge.
  int n_done = 0;
  int n_err = 0;
  int n_in_tok = 0;
  int n_out_tok = 0;
  logic prev_in = 1'b0;
  logic prev_out = 1'b0;

  bulk_host_initiator dut (
    .clk          (clk),
    .rst          (rst),
    .start_in     (start_in),
    .start_out    (start_out),
    .abort        (abort),
    .tx_complete  (tx_complete),
    .rx_valid     (rx_valid),
    .rx_type      (rx_type),
    .tx_en        (tx_en),
    .send_in_tok  (send_in_tok),
    .send_out_tok (send_out_tok),
    .send_data    (send_data),
    .send_ack     (send_ack),
    .rx_en        (rx_en),
    .busy         (busy),
    .xfer_done    (xfer_done),
    .xfer_err     (xfer_err),
    .retry_cnt    (retry_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (xfer_done) n_done <= n_done + 1;
    if (xfer_err)  n_err  <= n_err + 1;
    if (send_in_tok && !prev_in)   n_in_tok  <= n_in_tok + 1;
    if (send_out_tok && !prev_out) n_out_tok <= n_out_tok + 1;
    prev_in  <= send_in_tok;
    prev_out <= send_out_tok;
  end

  function automatic logic [10:0] outs();
    return {tx_en, send_in_tok, send_out_tok, send_data, send_ack, rx_en,
            busy, xfer_done, xfer_err, retry_cnt};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_tx();
    tx_complete = 1'b1;
    step();
    tx_complete = 1'b0;
  endtask

  task automatic rx(input logic [1:0] t);
    rx_valid = 1'b1;
    rx_type  = t;
    step();
    rx_valid = 1'b0;
    rx_type  = 2'b00;
  endtask

  int d0, e0, i0, o0, cnt;

  initial begin
    // Reset state
    #12;
    check("reset_outs", 32'(outs()), 32'h0);
    rst = 1'b0;
    step();
    check("idle_outs", 32'(outs()), 32'h0);

    // 1. IN success
    d0 = n_done;
    start_in = 1'b1; step(); start_in = 1'b0;
    check("t1_token_in", 32'({tx_en, send_in_tok, busy}), 32'b111);
    step(); step();
    check("t1_token_hold", 32'(send_in_tok), 32'd1);
    pulse_tx();
    check("t1_wait_data", 32'({rx_en, send_in_tok, tx_en}), 32'b100);
    step();
    rx(2'b11);
    check("t1_send_ack", 32'({tx_en, send_ack, rx_en}), 32'b110);
    pulse_tx();
    check("t1_done", 32'({xfer_done, retry_cnt}), 32'b100);
    step();
    check("t1_idle", 32'(outs()), 32'h0);
    check("t1_done_count", 32'(n_done - d0), 32'd1);

    // 2. OUT with one NAK
    d0 = n_done; o0 = n_out_tok;
    start_out = 1'b1; step(); start_out = 1'b0;
    check("t2_token_out", 32'({tx_en, send_out_tok}), 32'b11);
    pulse_tx();
    check("t2_send_data", 32'({tx_en, send_data}), 32'b11);
    pulse_tx();
    check("t2_wait_hs", 32'(rx_en), 32'd1);
    rx(2'b10);
    check("t2_retry", 32'(outs()), {21'd0, 11'b00000010000});
    step();
    check("t2_token_again", 32'({send_out_tok, retry_cnt}), 32'b101);
    pulse_tx(); pulse_tx();
    rx(2'b01);
    check("t2_done", 32'({xfer_done, retry_cnt}), 32'b101);
    step();
    check("t2_out_tok_count", 32'(n_out_tok - o0), 32'd2);
    check("t2_done_count", 32'(n_done - d0), 32'd1);

    // 3. Timeout exhaustion
    d0 = n_done; e0 = n_err; i0 = n_in_tok;
    start_in = 1'b1; step(); start_in = 1'b0;
    pulse_tx();
    for (int a = 0; a < 4; a++) begin
      cnt = 0;
      while (rx_en && cnt < 40) begin
        cnt++;
        step();
      end
      check($sformatf("t3_wait_len_%0d", a), 32'(cnt), 32'd16);
      step();
      if (a < 3) begin
        check($sformatf("t3_retry_tok_%0d", a), 32'({send_in_tok, retry_cnt}), {29'd0, 1'b1, 2'(a + 1)});
        pulse_tx();
      end
    end
    check("t3_err", 32'({xfer_err, xfer_done, retry_cnt}), 32'b1011);
    step();
    check("t3_idle", 32'(outs()), 32'h0);
    check("t3_counts", 32'({8'(n_in_tok - i0), 8'(n_err - e0), 8'(n_done - d0)}), 32'h040100);

    // 4. ACK coincides with timer expiry in WAIT_HS
    d0 = n_done;
    start_out = 1'b1; step(); start_out = 1'b0;
    pulse_tx(); pulse_tx();
    for (int k = 0; k < 15; k++) step();
    check("t4_still_wait", 32'(rx_en), 32'd1);
    rx(2'b01);
    check("t4_done", 32'({xfer_done, busy, retry_cnt}), 32'b1100);
    step();
    check("t4_done_count", 32'(n_done - d0), 32'd1);

    // 5a. Abort during SEND_DATA
    d0 = n_done; e0 = n_err;
    start_out = 1'b1; step(); start_out = 1'b0;
    pulse_tx();
    check("t5_send_data", 32'(send_data), 32'd1);
    abort = 1'b1; step(); abort = 1'b0;
    check("t5_abort_idle", 32'(outs()), 32'h0);
    step();
    check("t5_no_pulse", 32'({8'(n_done - d0), 8'(n_err - e0)}), 32'h0);

    // 5b. Async reset mid WAIT_DATA
    start_in = 1'b1; step(); start_in = 1'b0;
    pulse_tx();
    step(); step(); step();
    check("t5_pre_rst", 32'(rx_en), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("t5_async_rst", 32'(outs()), 32'h0);
    step();
    rst = 1'b0;
    step();
    check("t5_after_rst", 32'(outs()), 32'h0);

    // 6. Priority and busy masking
    d0 = n_done; o0 = n_out_tok;
    start_in = 1'b1; start_out = 1'b1; step();
    start_in = 1'b0;
    check("t6_in_wins", 32'({send_in_tok, send_out_tok}), 32'b10);
    step();
    start_out = 1'b0;
    check("t6_busy_mask", 32'({send_in_tok, send_out_tok}), 32'b10);
    pulse_tx();
    rx(2'b11);
    pulse_tx();
    check("t6_done", 32'(xfer_done), 32'd1);
    step(); step(); step();
    check("t6_stays_idle", 32'(outs()), 32'h0);
    check("t6_counts", 32'({8'(n_out_tok - o0), 8'(n_done - d0)}), 32'h0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
